// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester, response and memory-side signal bundle for dm_arbiter
interface dm_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          ack0;
   logic          ack1;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;
   logic [1:0]    grant;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output ack0, ack1, rdata0, rdata1, grant, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  ack0, ack1, rdata0, rdata1, grant, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port arbiter for the single-port data memory (ISSUE -> RESP per access)
// DM_ARB_RR_EN selects strict round-robin on ties instead of the hold-counter fairness scheme.
module dm_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int HOLD_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   dm_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    grant_q, grant_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          cur_we_q, cur_we_d;
   logic          last_q, last_d;

   logic any_req;
   logic both_req;
   logic win;
   logic start_issue;

`ifndef DM_ARB_RR_EN
   localparam int            HW       = $clog2(HOLD_MAX + 1);
   localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          served_q, served_d;
`endif

   // Arbitration is evaluated continuously but only consumed in IDLE and RESP.
   always_comb begin
      any_req  = bus.req0 | bus.req1;
      both_req = bus.req0 & bus.req1;
      win      = bus.req1;
      if (both_req) begin
`ifdef DM_ARB_RR_EN
         win = ~last_q;
`else
         if (!served_q) begin
            win = 1'b0;
         end else if (hold_cnt_q < HOLD_LIM) begin
            win = last_q;
         end else begin
            win = ~last_q;
         end
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      cur_we_d    = cur_we_q;
      last_d      = last_q;
      start_issue = 1'b0;
`ifndef DM_ARB_RR_EN
      hold_cnt_d  = hold_cnt_q;
      served_d    = served_q;
`endif

      case (state_q)
         S_IDLE: begin
            start_issue = any_req;
         end
         S_ISSUE: begin
            state_d = S_RESP;
            ack0_d  = grant_q[0];
            ack1_d  = grant_q[1];
         end
         S_RESP: begin
            if (!cur_we_q) begin
               if (grant_q[0]) rdata0_d = bus.mem_rdata;
               if (grant_q[1]) rdata1_d = bus.mem_rdata;
            end
            if (any_req) begin
               start_issue = 1'b1;
            end else begin
               state_d = S_IDLE;
               grant_d = 2'b00;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 2'b00;
         end
      endcase

      // Issue registers the winner's request so the requester may drop req early.
      if (start_issue) begin
         state_d     = S_ISSUE;
         grant_d     = win ? 2'b10 : 2'b01;
         mem_en_d    = 1'b1;
         mem_we_d    = win ? bus.we1 : bus.we0;
         mem_addr_d  = win ? bus.addr1 : bus.addr0;
         mem_wdata_d = win ? bus.wdata1 : bus.wdata0;
         cur_we_d    = win ? bus.we1 : bus.we0;
         last_d      = win;
`ifndef DM_ARB_RR_EN
         served_d    = 1'b1;
         if (both_req && (win == last_q)) begin
            if (hold_cnt_q < HOLD_LIM) hold_cnt_d = hold_cnt_q + 1'b1;
         end else begin
            hold_cnt_d = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grant_q     <= 2'b00;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         cur_we_q    <= 1'b0;
         last_q      <= 1'b1;
`ifndef DM_ARB_RR_EN
         hold_cnt_q  <= '0;
         served_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         cur_we_q    <= cur_we_d;
         last_q      <= last_d;
`ifndef DM_ARB_RR_EN
         hold_cnt_q  <= hold_cnt_d;
         served_q    <= served_d;
`endif
      end
   end

   // Memory data arrives in the ack cycle, so read data is forwarded then and held afterwards.
   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.rdata0    = (ack0_q && !cur_we_q) ? bus.mem_rdata : rdata0_q;
   assign bus.rdata1    = (ack1_q && !cur_we_q) ? bus.mem_rdata : rdata1_q;
   assign bus.grant     = grant_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - randomized self-checking bench for dm_arbiter with a reference memory and owner model
module tb_dm_arbiter;
   localparam int HOLD_MAX = 4;

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } op_t;

   logic clk;
   logic reset;
   logic tb_clr;
   logic mon_en;
   int   n_chk;
   int   n_pass;

   logic [7:0] dm      [256];
   logic [7:0] ref_mem [256];
   op_t        q0[$];
   op_t        q1[$];
   int         exp_own[$];

   dm_arbiter_if bus ();

   dm_arbiter #(.AW(8), .DW(8), .HOLD_MAX(HOLD_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tb_clr) begin
         for (int i = 0; i < 256; i++) dm[i] <= 8'h00;
         bus.mem_rdata <= 8'h00;
      end else if (bus.mem_en) begin
         if (bus.mem_we) dm[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata    <= dm[bus.mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      else             n_pass++;
   endtask

   always @(negedge clk) begin
      if (mon_en) check("ack_grant_exclusive", {30'd0, bus.grant == 2'b11, bus.ack0 & bus.ack1}, 32'd0);
   end

   // Owner of each access for two continuously-backlogged streams of n0 and n1 accesses.
   task automatic compute_owners(input int n0, input int n1);
      int prev;
      int repeats;
      int w;
      bit both;
      exp_own.delete();
      prev    = -1;
      repeats = 0;
      while (n0 + n1 > 0) begin
         both = (n0 > 0) && (n1 > 0);
         if (!both)           w = (n0 > 0) ? 0 : 1;
         else if (prev < 0)   w = 0;
`ifdef DM_ARB_RR_EN
         else                 w = 1 - prev;
`else
         else if (repeats < HOLD_MAX) w = prev;
         else                 w = 1 - prev;
         repeats = (both && w == prev) ? repeats + 1 : 0;
`endif
         exp_own.push_back(w);
         prev = w;
         if (w == 0) n0--; else n1--;
      end
   endtask

   task automatic drive_heads();
      bus.req0 = (q0.size() != 0);
      bus.req1 = (q1.size() != 0);
      if (q0.size() != 0) begin
         bus.we0 = q0[0].we; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].wdata;
      end
      if (q1.size() != 0) begin
         bus.we1 = q1[0].we; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].wdata;
      end
   endtask

   task automatic reset_pulse();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
   endtask

   task automatic run_streams();
      int  cyc;
      int  n_iss;
      int  n_ack;
      int  p;
      op_t op;
      compute_owners(q0.size(), q1.size());
      reset_pulse();
      drive_heads();
      cyc = 0; n_iss = 0; n_ack = 0;
      while ((q0.size() != 0 || q1.size() != 0) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (bus.mem_en && n_iss < exp_own.size()) begin
            p = exp_own[n_iss];
            if ((p == 1 && q1.size() != 0) || (p == 0 && q0.size() != 0)) begin
               op = (p == 1) ? q1[0] : q0[0];
               check("issue_grant", {30'd0, bus.grant}, (p == 1) ? 32'd2 : 32'd1);
               check("issue_addr", {24'd0, bus.mem_addr}, {24'd0, op.addr});
               check("issue_we", {31'd0, bus.mem_we}, {31'd0, op.we});
               if (op.we) check("issue_wdata", {24'd0, bus.mem_wdata}, {24'd0, op.wdata});
            end else begin
               check("issue_queue_empty", 32'd1, 32'd0);
            end
            n_iss++;
         end
         if (bus.ack0 || bus.ack1) begin
            p = bus.ack1 ? 1 : 0;
            if (n_ack < exp_own.size()) check("ack_owner", p, exp_own[n_ack]);
            check("ack_cycle", cyc, 2 * (n_ack + 1));
            if ((p == 1 && q1.size() != 0) || (p == 0 && q0.size() != 0)) begin
               op = (p == 1) ? q1.pop_front() : q0.pop_front();
               if (op.we) ref_mem[op.addr] = op.wdata;
               else check("ack_rdata", {24'd0, (p == 1) ? bus.rdata1 : bus.rdata0}, {24'd0, ref_mem[op.addr]});
            end else begin
               check("ack_queue_empty", 32'd1, 32'd0);
            end
            n_ack++;
            drive_heads();
         end
      end
      check("streams_done", q0.size() + q1.size(), 0);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
   endtask

   function automatic op_t mk(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
      op_t o;
      o.we = we; o.addr = addr; o.wdata = wdata;
      return o;
   endfunction

   initial begin
      n_chk  = 0;
      n_pass = 0;
      mon_en = 1'b0;
      tb_clr = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      reset    = 1'b1;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h20; bus.wdata0 = 8'h00;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;

      // T1: reset held with a pending request
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
         check("rst_ack0", {31'd0, bus.ack0}, 32'd0);
         check("rst_grant", {30'd0, bus.grant}, 32'd0);
         check("rst_rdata", {16'd0, bus.rdata0, bus.rdata1}, 32'd0);
         check("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
      end
      tb_clr = 1'b0;
      reset  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check("t1_mem_en_n1", {31'd0, bus.mem_en}, 32'd1);
      check("t1_mem_addr", {24'd0, bus.mem_addr}, 32'h20);
      @(negedge clk);
      check("t1_ack0_n2", {31'd0, bus.ack0}, 32'd1);
      check("t1_rdata0", {24'd0, bus.rdata0}, {24'd0, ref_mem[8'h20]});
      bus.req0 = 1'b0;
      @(negedge clk);
      check("t1_idle_mem_en", {31'd0, bus.mem_en}, 32'd0);

      // T2: host preload and read back
      q1.push_back(mk(1'b1, 8'h00, 8'h3F));
      q1.push_back(mk(1'b1, 8'h01, 8'h3F));
      q1.push_back(mk(1'b0, 8'h01, 8'h00));
      run_streams();
      check("t2_rdata1_hold", {24'd0, bus.rdata1}, 32'h3F);

      // T3: core read of a host-preloaded byte
      q1.push_back(mk(1'b1, 8'h10, 8'hA5));
      run_streams();
      q0.push_back(mk(1'b0, 8'h10, 8'h00));
      run_streams();
      check("t3_rdata0_hold", {24'd0, bus.rdata0}, 32'hA5);

      // T4/T5: sustained contention, back-to-back on both ports
      for (int i = 0; i < 11; i++) begin
         q0.push_back(mk(1'b0, 8'h10, 8'h00));
         q1.push_back(mk(1'b0, 8'h01, 8'h00));
      end
      run_streams();

      // T6: reset during ISSUE of a port-1 read
      reset_pulse();
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h01;
      @(negedge clk);
      check("t6_issue", {31'd0, bus.mem_en}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("t6_ack1", {31'd0, bus.ack1}, 32'd0);
      check("t6_mem_en", {31'd0, bus.mem_en}, 32'd0);
      check("t6_grant", {30'd0, bus.grant}, 32'd0);
      check("t6_rdata1", {24'd0, bus.rdata1}, 32'd0);
      bus.req1 = 1'b0;
      reset    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_no_ack1", {31'd0, bus.ack1}, 32'd0);
      end

      // Randomized mixed streams
      for (int r = 0; r < 8; r++) begin
         int n0;
         int n1;
         n0 = $urandom_range(0, 9);
         n1 = $urandom_range(1, 9);
         for (int i = 0; i < n0; i++)
            q0.push_back(mk(1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)), 8'($urandom)));
         for (int i = 0; i < n1; i++)
            q1.push_back(mk(1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)), 8'($urandom)));
         run_streams();
      end

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
